// File: rtl/tetris_move_checker.sv
// Sequential collision checker: scans the 4x4 block pattern one cell per cycle against the walled field.
// Optional macro CHECK_MOVE_EARLY_EXIT_EN ends the scan right after the first colliding cell.
module tetris_move_checker #(
  parameter  int ROW_CNT = 20,
  parameter  int COL_CNT = 10,
  parameter  int COLOR_W = 3,
  localparam int EXT_ROW = ROW_CNT + 2,
  localparam int EXT_COL = COL_CNT + 2,
  localparam int XW      = $clog2(COL_CNT) + 1,
  localparam int YW      = $clog2(ROW_CNT) + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        run_i,
  input  logic [2:0]                  req_move_i,
  input  logic [63:0]                 block_data_i,
  input  logic [COLOR_W-1:0]          block_color_i,
  input  logic [1:0]                  block_rot_i,
  input  logic signed [XW-1:0]        block_x_i,
  input  logic signed [YW-1:0]        block_y_i,
  input  logic [EXT_ROW*EXT_COL-1:0]  field_i,
  output logic                        done_o,
  output logic                        can_move_o,
  output logic [1:0]                  move_x_o,
  output logic [1:0]                  move_y_o
);

  localparam int CW = XW + 1;
  localparam int RW = YW + 1;
  localparam int FW = $clog2(EXT_ROW * EXT_COL);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DONE} state_t;

  state_t              r_state, w_state_next;
  logic [3:0]          r_idx, w_idx_next;
  logic                r_coll, w_coll_next;
  logic [63:0]         r_data, w_data_next;
  logic [1:0]          r_rot, w_rot_next;
  logic signed [XW-1:0] r_x, w_x_next;
  logic signed [YW-1:0] r_y, w_y_next;
  logic signed [1:0]   r_dx, w_dx_next;
  logic signed [1:0]   r_dy, w_dy_next;
  logic                r_done, w_done_next;
  logic                r_can, w_can_next;
  logic [1:0]          r_mx, w_mx_next;
  logic [1:0]          r_my, w_my_next;

  logic                w_unused_color;
  logic                w_pat;
  logic [RW-1:0]       w_row;
  logic [CW-1:0]       w_col;
  logic                w_row_oob;
  logic                w_col_oob;
  logic [FW-1:0]       w_fidx;
  logic                w_occ;
  logic                w_hit;

  // Colour travels alongside the block but never affects the fit decision.
  assign w_unused_color = ^block_color_i;

  // Target cell in two's complement, one bit wider than the position inputs.
  assign w_pat = r_data[{r_rot, r_idx}];
  assign w_row = {{(RW-YW){r_y[YW-1]}}, r_y} + {{(RW-2){r_dy[1]}}, r_dy} + {{(RW-2){1'b0}}, r_idx[3:2]};
  assign w_col = {{(CW-XW){r_x[XW-1]}}, r_x} + {{(CW-2){r_dx[1]}}, r_dx} + {{(CW-2){1'b0}}, r_idx[1:0]};

  assign w_row_oob = w_row[RW-1] || (w_row[RW-2:0] >= (RW-1)'(EXT_ROW));
  assign w_col_oob = w_col[CW-1] || (w_col[CW-2:0] >= (CW-1)'(EXT_COL));
  assign w_fidx    = FW'(w_row[RW-2:0]) * FW'(EXT_COL) + FW'(w_col[CW-2:0]);
  assign w_occ     = !w_row_oob && !w_col_oob && field_i[w_fidx];
  assign w_hit     = w_pat && (w_row_oob || w_col_oob || w_occ);

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_coll_next  = r_coll;
    w_data_next  = r_data;
    w_rot_next   = r_rot;
    w_x_next     = r_x;
    w_y_next     = r_y;
    w_dx_next    = r_dx;
    w_dy_next    = r_dy;
    w_done_next  = 1'b0;
    w_can_next   = r_can;
    w_mx_next    = r_mx;
    w_my_next    = r_my;
    case (r_state)
      S_IDLE: begin
        if (run_i) begin
          w_state_next = S_CHECK;
          w_idx_next   = 4'd0;
          w_coll_next  = 1'b0;
          w_data_next  = block_data_i;
          w_x_next     = block_x_i;
          w_y_next     = block_y_i;
          w_rot_next   = block_rot_i;
          w_dx_next    = 2'sb00;
          w_dy_next    = 2'sb00;
          case (req_move_i)
            3'd1:    w_dx_next  = 2'sb11;
            3'd2:    w_dx_next  = 2'sb01;
            3'd3:    w_rot_next = block_rot_i + 2'd1;
            3'd4:    w_rot_next = block_rot_i;
            default: w_dy_next  = 2'sb01;
          endcase
        end
      end
      S_CHECK: begin
        w_coll_next = r_coll | w_hit;
        w_idx_next  = r_idx + 4'd1;
        if (r_idx == 4'd15) w_state_next = S_DONE;
`ifdef CHECK_MOVE_EARLY_EXIT_EN
        if (w_hit) w_state_next = S_DONE;
`endif
      end
      S_DONE: begin
        w_state_next = S_IDLE;
        w_done_next  = 1'b1;
        w_can_next   = !r_coll;
        w_mx_next    = r_coll ? 2'b00 : r_dx;
        w_my_next    = r_coll ? 2'b00 : r_dy;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
      r_coll  <= 1'b0;
      r_data  <= 64'd0;
      r_rot   <= 2'd0;
      r_x     <= '0;
      r_y     <= '0;
      r_dx    <= 2'sb00;
      r_dy    <= 2'sb00;
      r_done  <= 1'b0;
      r_can   <= 1'b0;
      r_mx    <= 2'b00;
      r_my    <= 2'b00;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_coll  <= w_coll_next;
      r_data  <= w_data_next;
      r_rot   <= w_rot_next;
      r_x     <= w_x_next;
      r_y     <= w_y_next;
      r_dx    <= w_dx_next;
      r_dy    <= w_dy_next;
      r_done  <= w_done_next;
      r_can   <= w_can_next;
      r_mx    <= w_mx_next;
      r_my    <= w_my_next;
    end
  end

  assign done_o     = r_done;
  assign can_move_o = r_can;
  assign move_x_o   = r_mx;
  assign move_y_o   = r_my;

endmodule

// File: tb/tb_tetris_move_checker.sv
// Directed bench for tetris_move_checker: hand-computed moves against a walled 22x12 field.
// Latency checks adapt when CHECK_MOVE_EARLY_EXIT_EN is defined.
module tb_tetris_move_checker;
  localparam int FB = 22 * 12;

  logic               clk = 1'b0;
  logic               rst;
  logic               run;
  logic [2:0]         req;
  logic [63:0]        data;
  logic [2:0]         color;
  logic [1:0]         rot;
  logic signed [4:0]  bx;
  logic signed [5:0]  by;
  logic [FB-1:0]      field;
  logic               done;
  logic               can;
  logic [1:0]         mx;
  logic [1:0]         my;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [63:0] O_BLK = {4{16'h0660}};
  localparam logic [63:0] I_BLK = {16'h2222, 16'h0F00, 16'h4444, 16'h00F0};

  always #5 clk = ~clk;

  tetris_move_checker dut (
    .clk_i(clk), .rst_i(rst), .run_i(run), .req_move_i(req),
    .block_data_i(data), .block_color_i(color), .block_rot_i(rot),
    .block_x_i(bx), .block_y_i(by), .field_i(field),
    .done_o(done), .can_move_o(can), .move_x_o(mx), .move_y_o(my)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [FB-1:0] clean_field();
    logic [FB-1:0] f;
    f = '0;
    for (int r = 0; r < 22; r++)
      for (int c = 0; c < 12; c++)
        if (r == 21 || c == 0 || c == 11) f[r*12+c] = 1'b1;
    return f;
  endfunction

  // Called at posedge+1; returns at posedge+1 one cycle after done.
  task automatic do_move(input string tag, input logic [2:0] rq, input logic [63:0] d,
                         input logic [1:0] rt, input int x, input int y,
                         input logic ec, input logic [1:0] emx, input logic [1:0] emy);
    int n;
    logic seen;
    req = rq; data = d; rot = rt; bx = x[4:0]; by = y[5:0]; run = 1'b1;
    @(posedge clk); #1 run = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1'b1;
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
`ifdef CHECK_MOVE_EARLY_EXIT_EN
    chk({tag, "_lat_range"}, 32'(n >= 2 && n <= 17), 32'd1);
`else
    chk({tag, "_lat"}, n, 32'd17);
`endif
    chk({tag, "_can"}, 32'(can), 32'(ec));
    chk({tag, "_mx"}, 32'(mx), 32'(emx));
    chk({tag, "_my"}, 32'(my), 32'(emy));
    $display("move %s req=%0d rot=%0d x=%0d y=%0d -> lat=%0d can=%0b mx=%0d my=%0d",
             tag, rq, rt, x, y, n, can, $signed(mx), $signed(my));
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    int cnt;
    int first;
    rst = 1'b1; run = 1'b1; req = 3'd0; data = O_BLK; color = 3'd5; rot = 2'd0;
    bx = 5'sd4; by = 6'sd0; field = clean_field();

    // Reset held with run asserted: everything quiet.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_can", 32'(can), 32'd0);
    chk("rst_mx", 32'(mx), 32'd0);
    chk("rst_my", 32'(my), 32'd0);
    run = 1'b0; rst = 1'b0;
    cnt = 0;
    repeat (20) begin @(posedge clk); #1; if (done) cnt++; end
    chk("post_rst_no_done", cnt, 32'd0);

    do_move("down_fit",   3'd0, O_BLK, 2'd0,  4,  0, 1'b1, 2'b00, 2'b01);
    do_move("left_wall",  3'd1, O_BLK, 2'd0, -1,  0, 1'b0, 2'b00, 2'b00);
    do_move("left_fit",   3'd1, O_BLK, 2'd0,  4,  3, 1'b1, 2'b11, 2'b00);
    do_move("right_fit",  3'd2, O_BLK, 2'd0,  7,  3, 1'b1, 2'b01, 2'b00);
    do_move("right_wall", 3'd2, O_BLK, 2'd0,  8,  3, 1'b0, 2'b00, 2'b00);
    do_move("floor_y19",  3'd0, O_BLK, 2'd0,  4, 19, 1'b0, 2'b00, 2'b00);
    do_move("floor_y18",  3'd0, O_BLK, 2'd0,  4, 18, 1'b0, 2'b00, 2'b00);
    do_move("floor_y17",  3'd0, O_BLK, 2'd0,  4, 17, 1'b1, 2'b00, 2'b01);
    do_move("req5_down",  3'd5, O_BLK, 2'd0,  4,  0, 1'b1, 2'b00, 2'b01);
    do_move("rot_wall",   3'd3, I_BLK, 2'd3,  9,  5, 1'b0, 2'b00, 2'b00);
    do_move("rot_fit",    3'd3, I_BLK, 2'd3,  7,  5, 1'b1, 2'b00, 2'b00);
    field[6*12+9] = 1'b1;
    do_move("rot_occ",    3'd3, I_BLK, 2'd3,  7,  5, 1'b0, 2'b00, 2'b00);
    field = clean_field();
    do_move("appear_fit", 3'd4, I_BLK, 2'd0,  4, -1, 1'b1, 2'b00, 2'b00);
    field[0*12+5] = 1'b1;
    do_move("appear_occ", 3'd4, I_BLK, 2'd0,  4, -1, 1'b0, 2'b00, 2'b00);
    field = clean_field();

    // Second run pulse mid-scan must be ignored.
    req = 3'd0; data = O_BLK; rot = 2'd0; bx = 5'sd4; by = 6'sd0; run = 1'b1;
    @(posedge clk); #1 run = 1'b0;
    n = 0; cnt = 0; first = 0;
    repeat (45) begin
      @(posedge clk); #1;
      n++;
      if (n == 4) begin req = 3'd1; run = 1'b1; end
      if (n == 5) run = 1'b0;
      if (done) begin
        cnt++;
        if (first == 0) begin
          first = n;
          chk("busy_can", 32'(can), 32'd1);
          chk("busy_my", 32'(my), 32'd1);
          chk("busy_mx", 32'(mx), 32'd0);
        end
      end
    end
    chk("busy_single_done", cnt, 32'd1);
    chk("busy_lat", first, 32'd17);
    $display("move busy_run req=0 x=4 y=0 -> dones=%0d first=%0d", cnt, first);

    // Reset in the middle of a scan aborts at once and suppresses done.
    data = O_BLK; req = 3'd0; bx = 5'sd4; by = 6'sd0; run = 1'b1;
    @(posedge clk); #1 run = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_can", 32'(can), 32'd0);
    chk("abort_my", 32'(my), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    cnt = 0;
    repeat (25) begin @(posedge clk); #1; if (done) cnt++; end
    chk("abort_no_done", cnt, 32'd0);
    $display("move abort_reset -> dones_after=%0d", cnt);

    do_move("recover",    3'd0, O_BLK, 2'd0,  4,  0, 1'b1, 2'b00, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
